// File: rtl/rgen_host_if_apb.sv
// APB slave front end for a generated register block.
// Turns each APB transfer into a one-cycle internal register command and
// returns the decoded read data / hit status as PRDATA / PSLVERR with PREADY.
// Optional build macro: RGEN_APB_PSTRB_EN adds the i_pstrb port and derives
// the bit write mask from the byte strobes; without it the mask is all ones.
module rgen_host_if_apb #(
  parameter  int ADDRESS_WIDTH = 16,
  parameter  int DATA_WIDTH    = 32,
  localparam int STROBE_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_psel,
  input  logic                     i_penable,
  input  logic [ADDRESS_WIDTH-1:0] i_paddr,
  input  logic                     i_pwrite,
  input  logic [DATA_WIDTH-1:0]    i_pwdata,
`ifdef RGEN_APB_PSTRB_EN
  input  logic [STROBE_WIDTH-1:0]  i_pstrb,
`endif
  output logic                     o_pready,
  output logic [DATA_WIDTH-1:0]    o_prdata,
  output logic                     o_pslverr,
  output logic                     o_command_valid,
  output logic [ADDRESS_WIDTH-1:0] o_address,
  output logic                     o_write,
  output logic [DATA_WIDTH-1:0]    o_write_data,
  output logic [DATA_WIDTH-1:0]    o_write_mask,
  input  logic                     i_hit,
  input  logic [DATA_WIDTH-1:0]    i_read_data
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMMAND  = 2'd1,
    RESPONSE = 2'd2
  } state_t;

  state_t                   state_q;
  logic                     command_valid_q;
  logic [ADDRESS_WIDTH-1:0] address_q;
  logic                     write_q;
  logic [DATA_WIDTH-1:0]    write_data_q;
  logic [DATA_WIDTH-1:0]    write_mask_q;
  logic [DATA_WIDTH-1:0]    write_mask_d;
  logic                     pready_q;
  logic                     pslverr_q;
  logic [DATA_WIDTH-1:0]    prdata_q;

`ifdef RGEN_APB_PSTRB_EN
  // Expand each byte strobe into eight mask bits.
  function automatic logic [DATA_WIDTH-1:0] strb_to_mask(input logic [STROBE_WIDTH-1:0] strb);
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int k = 0; k < STROBE_WIDTH; k++) begin
      m[8*k +: 8] = {8{strb[k]}};
    end
    return m;
  endfunction

  // Mask to latch at setup: follows the byte strobes.
  always_comb begin
    write_mask_d = strb_to_mask(i_pstrb);
  end
`else
  // Mask to latch at setup: every bit writable when strobes are absent.
  always_comb begin
    write_mask_d = '1;
  end
`endif

  // Transfer FSM: latches the setup phase, strobes the command for one
  // cycle, captures the decode result and holds the response until access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      command_valid_q <= 1'b0;
      address_q       <= '0;
      write_q         <= 1'b0;
      write_data_q    <= '0;
      write_mask_q    <= '0;
      pready_q        <= 1'b0;
      pslverr_q       <= 1'b0;
      prdata_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // A lone penable without a setup phase is ignored.
          if (i_psel && !i_penable) begin
            address_q       <= i_paddr;
            write_q         <= i_pwrite;
            write_data_q    <= i_pwdata;
            write_mask_q    <= write_mask_d;
            command_valid_q <= 1'b1;
            state_q         <= COMMAND;
          end
        end
        COMMAND: begin
          command_valid_q <= 1'b0;
          if (i_psel) begin
            // Decode result is only valid during the command cycle.
            pready_q  <= 1'b1;
            pslverr_q <= !i_hit;
            prdata_q  <= (!write_q && i_hit) ? i_read_data : '0;
            state_q   <= RESPONSE;
          end else begin
            state_q <= IDLE;
          end
        end
        RESPONSE: begin
          if (!i_psel || i_penable) begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            state_q   <= IDLE;
          end
        end
        default: begin
          command_valid_q <= 1'b0;
          pready_q        <= 1'b0;
          pslverr_q       <= 1'b0;
          prdata_q        <= '0;
          state_q         <= IDLE;
        end
      endcase
    end
  end

  assign o_pready        = pready_q;
  assign o_prdata        = prdata_q;
  assign o_pslverr       = pslverr_q;
  assign o_command_valid = command_valid_q;
  assign o_address       = address_q;
  assign o_write         = write_q;
  assign o_write_data    = write_data_q;
  assign o_write_mask    = write_mask_q;

endmodule

// File: tb/tb_rgen_host_if_apb.sv
// Self-checking bench for rgen_host_if_apb (scoreboard of commands/responses).
module tb_rgen_host_if_apb;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_psel = 1'b0;
  logic          i_penable = 1'b0;
  logic [AW-1:0] i_paddr = '0;
  logic          i_pwrite = 1'b0;
  logic [DW-1:0] i_pwdata = '0;
  logic [SW-1:0] i_pstrb = '0;
  logic          o_pready;
  logic [DW-1:0] o_prdata;
  logic          o_pslverr;
  logic          o_command_valid;
  logic [AW-1:0] o_address;
  logic          o_write;
  logic [DW-1:0] o_write_data;
  logic [DW-1:0] o_write_mask;
  logic          i_hit = 1'b0;
  logic [DW-1:0] i_read_data = '0;

  rgen_host_if_apb #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_psel          (i_psel),
    .i_penable       (i_penable),
    .i_paddr         (i_paddr),
    .i_pwrite        (i_pwrite),
    .i_pwdata        (i_pwdata),
`ifdef RGEN_APB_PSTRB_EN
    .i_pstrb         (i_pstrb),
`endif
    .o_pready        (o_pready),
    .o_prdata        (o_prdata),
    .o_pslverr       (o_pslverr),
    .o_command_valid (o_command_valid),
    .o_address       (o_address),
    .o_write         (o_write),
    .o_write_data    (o_write_data),
    .o_write_mask    (o_write_mask),
    .i_hit           (i_hit),
    .i_read_data     (i_read_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] mask;
  } cmd_t;
  typedef struct {
    logic [DW-1:0] prdata;
    logic          pslverr;
  } rsp_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_cmd_cyc = 0;
  int n_pready = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_mask(input logic [SW-1:0] s);
    logic [DW-1:0] m;
`ifdef RGEN_APB_PSTRB_EN
    for (int k = 0; k < SW; k++) m[8*k +: 8] = s[k] ? 8'hFF : 8'h00;
`else
    m = {DW{1'b1}};
`endif
    return m;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: pop and compare whatever the DUT presents.
  always @(negedge clk) begin
    if (o_command_valid) begin
      if (cmd_q.size() == 0) chk("cmd_unexpected", 1, 0);
      else begin
        cmd_t c;
        c = cmd_q.pop_front();
        chk("cmd_addr", DW'(o_address), DW'(c.addr));
        chk("cmd_write", DW'(o_write), DW'(c.wr));
        chk("cmd_wdata", o_write_data, c.wdata);
        chk("cmd_mask", o_write_mask, c.mask);
      end
    end
    if (o_pready) begin
      n_pready++;
      if (rsp_q.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        rsp_t r;
        r = rsp_q.pop_front();
        chk("rsp_prdata", o_prdata, r.prdata);
        chk("rsp_pslverr", DW'(o_pslverr), DW'(r.pslverr));
      end
    end
  end

  // Full APB transfer; the bench plays the decode logic via hit/rdata.
  task automatic apb_xfer(input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] wd,
                          input logic [SW-1:0] s, input logic hit, input logic [DW-1:0] rd);
    cmd_t c;
    rsp_t r;
    c.addr = a; c.wr = wr; c.wdata = wd; c.mask = exp_mask(s);
    r.pslverr = !hit;
    r.prdata  = (!wr && hit) ? rd : '0;
    cmd_q.push_back(c);
    rsp_q.push_back(r);
    i_psel = 1; i_penable = 0; i_paddr = a; i_pwrite = wr; i_pwdata = wd; i_pstrb = s;
    i_hit = hit; i_read_data = rd;
    @(posedge clk); #1;
    chk("cv_at_n1", DW'(o_command_valid), 1);
    chk("rdy_at_n1", DW'(o_pready), 0);
    last_cmd_cyc = cyc;
    i_penable = 1;
    @(posedge clk); #1;
    // Decode inputs change after the command cycle; response must not follow.
    i_hit = !hit; i_read_data = ~rd;
    i_pwdata = ~wd; i_paddr = ~a;
    chk("cv_at_n2", DW'(o_command_valid), 0);
    chk("rdy_at_n2", DW'(o_pready), 1);
    @(posedge clk); #1;
    chk("rdy_done", DW'(o_pready), 0);
    i_psel = 0; i_penable = 0;
  endtask

  task automatic idle(input int n);
    i_psel = 0; i_penable = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  int c0;

  initial begin
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pready", DW'(o_pready), 0);
    chk("rst_prdata", o_prdata, 0);
    chk("rst_pslverr", DW'(o_pslverr), 0);
    chk("rst_cv", DW'(o_command_valid), 0);
    chk("rst_addr", DW'(o_address), 0);
    chk("rst_mask", o_write_mask, 0);
    rst_n = 1;
    idle(2);

    // Write hit, read hit, read miss, write miss.
    apb_xfer(16'h0010, 1, 32'hDEADBEEF, 4'hF, 1, 32'hA5A5A5A5);
    idle(2);
    apb_xfer(16'h0004, 0, 32'h0, 4'hF, 1, 32'h12345678);
    idle(1);
    apb_xfer(16'h0FF0, 0, 32'h0, 4'hF, 0, 32'hFFFFFFFF);
    idle(1);
    apb_xfer(16'h0200, 1, 32'h11223344, 4'hF, 0, 32'h55555555);
    idle(1);

    // Byte strobes (all ones mask expected when the feature is absent).
    apb_xfer(16'h0020, 1, 32'hCAFEF00D, 4'b0101, 1, 32'h0);
    apb_xfer(16'h0024, 1, 32'h0BADBEEF, 4'b0000, 1, 32'h0);
    idle(1);

    // Back-to-back write then read: strobes three cycles apart.
    apb_xfer(16'h0030, 1, 32'h01020304, 4'hF, 1, 32'h0);
    c0 = last_cmd_cyc;
    apb_xfer(16'h0034, 0, 32'h0, 4'hF, 1, 32'h89ABCDEF);
    chk("b2b_spacing", DW'(last_cmd_cyc - c0), 3);
    idle(1);

    // penable without setup is ignored.
    i_psel = 1; i_penable = 1;
    @(posedge clk); #1;
    chk("penable_only_cv", DW'(o_command_valid), 0);
    @(posedge clk); #1;
    chk("penable_only_rdy", DW'(o_pready), 0);
    idle(1);

    // Abort: psel dropped during the command cycle.
    begin
      cmd_t c;
      c.addr = 16'h0040; c.wr = 1; c.wdata = 32'h77778888; c.mask = exp_mask(4'hF);
      cmd_q.push_back(c);
    end
    n_pready = 0;
    i_psel = 1; i_penable = 0; i_paddr = 16'h0040; i_pwrite = 1; i_pwdata = 32'h77778888;
    i_pstrb = 4'hF; i_hit = 1;
    @(posedge clk); #1;
    chk("abort_cv", DW'(o_command_valid), 1);
    i_psel = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_rdy", DW'(n_pready), 0);
    chk("abort_rsp_empty", DW'(rsp_q.size()), 0);

    // Reset asserted in the command cycle drops the transfer.
    begin
      cmd_t c;
      c.addr = 16'h0050; c.wr = 0; c.wdata = 32'h0; c.mask = exp_mask(4'hF);
      cmd_q.push_back(c);
    end
    i_psel = 1; i_penable = 0; i_paddr = 16'h0050; i_pwrite = 0; i_pwdata = 32'h0;
    i_hit = 1; i_read_data = 32'h31415926;
    @(posedge clk); #1;
    chk("rstmid_cv", DW'(o_command_valid), 1);
    i_penable = 1;
    @(negedge clk); #1;
    rst_n = 0;
    #1;
    chk("rstmid_cv_clr", DW'(o_command_valid), 0);
    chk("rstmid_addr_clr", DW'(o_address), 0);
    @(posedge clk); #1;
    chk("rstmid_no_rdy", DW'(o_pready), 0);
    chk("rstmid_prdata", o_prdata, 0);
    rst_n = 1;
    idle(2);
    chk("rstmid_still_idle", DW'(o_pready), 0);
    apb_xfer(16'h0060, 0, 32'h0, 4'hF, 1, 32'h27182818);
    idle(2);

    chk("cmd_q_drained", DW'(cmd_q.size()), 0);
    chk("rsp_q_drained", DW'(rsp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
